// File: rtl/tag_pio_pkg.sv
// Shared definitions for the Nios PIO-compatible status input port.
package tag_pio_pkg;

    // Word offsets of the PIO-compatible register map.
    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_DIR     = 2'd1;
    localparam logic [1:0] PIO_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_EDGECAP = 2'd3;

    // Which debounced-level transitions are recorded in the edge-capture register.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/tag_pio_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser, stability counter and
// debounced level, with one-cycle rise/fall strobes that coincide with the
// cycle in which the debounced level is about to change.
module tag_pio_debounce
    import tag_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Next-state: count consecutive cycles where the synchronised pin differs
    // from the accepted level; accept the new level when the count completes.
    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        accept  = (sync2_q != deb_q) && (cnt_q == LAST);
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (accept) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise = accept && sync2_q;
        fall = accept && !sync2_q;
    end

    // State registers; synchronisers reset to the debounced reset level so
    // that reset release never looks like an input transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            deb_q   <= RESET_VALUE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/tag_nios_system_wifi_status.sv
// Avalon-MM PIO-compatible input port for the Wi-Fi module status lines:
// debounced levels, sticky edge capture with write-1-to-clear, interrupt mask
// and a level interrupt to the Nios.
module tag_nios_system_wifi_status
    import tag_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] deb, rise, fall, hit, w1c;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr_en;
    logic             writedata_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tag_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (RESET_VALUE[i])
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[i]),
            .deb    (deb[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    // Select which debounced transitions count as a capturable edge.
    always_comb begin
        if (EDGE_TYPE == int'(EDGE_RISE)) begin
            hit = rise;
        end else if (EDGE_TYPE == int'(EDGE_FALL)) begin
            hit = fall;
        end else begin
            hit = rise | fall;
        end
    end

    assign wr_en            = chipselect && !write_n;
    assign writedata_unused = ^writedata;

    // Register next-state: mask write, and capture where a new edge beats a same-cycle clear.
    always_comb begin
        irqmask_d = irqmask_q;
        w1c       = '0;
        if (wr_en && (address == PIO_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == PIO_EDGECAP)) begin
            w1c = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~w1c) | hit;
    end

    // Mask and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-wait-state read mux, zero-extended and quiet when not selected.
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                PIO_DATA:    readdata[WIDTH-1:0] = deb;
                PIO_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
                PIO_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
                default:     readdata = '0;
            endcase
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_tag_nios_system_wifi_status.sv
// Self-checking bench: two instances (any-edge with reset level 0101, and
// falling-edge with reset level 0000) share all inputs and are compared every
// cycle against a window-based behavioural model, plus a register-access
// vector table and directed timing sequences.
module tb_tag_nios_system_wifi_status;
    import tag_pio_pkg::*;

    localparam int         W    = 4;
    localparam int         D    = 8;
    localparam logic [3:0] RV_A = 4'b0101;
    localparam logic [3:0] RV_B = 4'b0000;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    logic [3:0]  in_port    = 4'b0101;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int nVectors     = 0;
    int nMiscompares = 0;

    tag_nios_system_wifi_status #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .RESET_VALUE(RV_A)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_port), .irq(irq_a)
    );

    tag_nios_system_wifi_status #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .RESET_VALUE(RV_B)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_port), .irq(irq_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_s1[2], m_s2[2], m_deb[2], m_mask[2], m_cap[2];
    logic [3:0] hist[2][D];
    int         histLen[2];

    function automatic logic [3:0] rvOf(input int d);
        return (d == 0) ? RV_A : RV_B;
    endfunction

    function automatic int edgeTypeOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic modelReset(input int d);
        m_s1[d]    = rvOf(d);
        m_s2[d]    = rvOf(d);
        m_deb[d]   = rvOf(d);
        m_mask[d]  = 4'h0;
        m_cap[d]   = 4'h0;
        histLen[d] = 0;
    endtask

    // A level is accepted once the synchronised pin has shown the same new
    // value for the last D cycles.
    task automatic modelStep(input int d);
        logic [3:0] s2now, newDeb, capt, w1c;
        logic       same;
        s2now  = m_s2[d];
        newDeb = m_deb[d];
        capt   = 4'h0;
        for (int j = 0; j < D - 1; j++) hist[d][j] = hist[d][j+1];
        hist[d][D-1] = s2now;
        if (histLen[d] < D) histLen[d]++;
        for (int b = 0; b < W; b++) begin
            if (histLen[d] == D && s2now[b] != m_deb[d][b]) begin
                same = 1'b1;
                for (int j = 0; j < D; j++) if (hist[d][j][b] != s2now[b]) same = 1'b0;
                if (same) begin
                    newDeb[b] = s2now[b];
                    if (edgeTypeOf(d) == 2 || (edgeTypeOf(d) == 0 && s2now[b]) ||
                        (edgeTypeOf(d) == 1 && !s2now[b]))
                        capt[b] = 1'b1;
                end
            end
        end
        w1c = (chipselect && !write_n && address == PIO_EDGECAP) ? writedata[3:0] : 4'h0;
        m_cap[d] = (m_cap[d] & ~w1c) | capt;
        if (chipselect && !write_n && address == PIO_IRQMASK) m_mask[d] = writedata[3:0];
        m_deb[d] = newDeb;
        m_s2[d]  = m_s1[d];
        m_s1[d]  = in_port;
    endtask

    function automatic logic [31:0] modelRead(input int d, input logic [1:0] a, input logic cs);
        if (!cs) return 32'h0;
        case (a)
            PIO_DATA:    return {28'h0, m_deb[d]};
            PIO_IRQMASK: return {28'h0, m_mask[d]};
            PIO_EDGECAP: return {28'h0, m_cap[d]};
            default:     return 32'h0;
        endcase
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) modelReset(d);
        forever begin
            @(posedge clk or negedge reset_n);
            for (int d = 0; d < 2; d++) begin
                if (!reset_n) modelReset(d);
                else modelStep(d);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_rd_a", rd_a, modelRead(0, address, chipselect));
            checkOutput("model_rd_b", rd_b, modelRead(1, address, chipselect));
            checkOutput("model_irq_a", {31'h0, irq_a}, {31'h0, |(m_cap[0] & m_mask[0])});
            checkOutput("model_irq_b", {31'h0, irq_b}, {31'h0, |(m_cap[1] & m_mask[1])});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit expired");
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expIrq;
    } vec_t;

    vec_t vecs[15];

    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        chipselect = v.cs;
        write_n    = v.wn;
        address    = v.addr;
        writedata  = v.wdata;
        @(negedge clk);
        #1;
        checkOutput($sformatf("vec%0d_rd", idx), rd_a, v.expRd);
        checkOutput($sformatf("vec%0d_irq", idx), {31'h0, irq_a}, {31'h0, v.expIrq});
    endtask

    task automatic peek(input logic [1:0] a);
        @(negedge clk);
        #1;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] data);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = data;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int hold;
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'h5, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'hF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 32'hA,        32'h5, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'h5, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 32'hF,        32'h0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 32'hF,        32'h0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'hF, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};

        // Reset with pins held at the A reset level.
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);
        repeat (12) @(posedge clk);

        // Glitch of 7 cycles on bit1 is rejected.
        @(posedge clk);
        #1;
        in_port = 4'b0111;
        repeat (7) @(posedge clk);
        #1;
        in_port = 4'b0101;
        repeat (12) @(posedge clk);
        peek(PIO_DATA);
        checkOutput("glitch_data_a", rd_a, 32'h5);
        checkOutput("glitch_data_b", rd_b, 32'h5);
        peek(PIO_EDGECAP);
        checkOutput("glitch_cap_a", rd_a, 32'h0);
        checkOutput("glitch_cap_b", rd_b, 32'h0);

        // Stable rise on bit1 is accepted exactly D+1 edges after first sample.
        @(posedge clk);
        #1;
        in_port = 4'b0111;
        repeat (9) @(posedge clk);
        peek(PIO_DATA);
        checkOutput("latency_early_a", rd_a, 32'h5);
        checkOutput("latency_early_b", rd_b, 32'h5);
        @(posedge clk);
        peek(PIO_DATA);
        checkOutput("latency_data_a", rd_a, 32'h7);
        checkOutput("latency_data_b", rd_b, 32'h7);
        peek(PIO_EDGECAP);
        checkOutput("rise_cap_a", rd_a, 32'h2);
        checkOutput("rise_cap_b", rd_b, 32'h0);

        // Mask enables irq; W1C clears it; mask removal drops a pending irq.
        busWrite(PIO_IRQMASK, 32'h2);
        peek(PIO_EDGECAP);
        checkOutput("mask_irq_a", {31'h0, irq_a}, 32'h1);
        checkOutput("mask_irq_b", {31'h0, irq_b}, 32'h0);
        busWrite(PIO_EDGECAP, 32'h2);
        peek(PIO_EDGECAP);
        checkOutput("w1c_cap_a", rd_a, 32'h0);
        checkOutput("w1c_irq_a", {31'h0, irq_a}, 32'h0);
        @(posedge clk);
        #1;
        in_port = 4'b0101;
        repeat (12) @(posedge clk);
        peek(PIO_EDGECAP);
        checkOutput("fall1_cap_a", rd_a, 32'h2);
        checkOutput("fall1_cap_b", rd_b, 32'h2);
        checkOutput("fall1_irq_a", {31'h0, irq_a}, 32'h1);
        checkOutput("fall1_irq_b", {31'h0, irq_b}, 32'h1);
        busWrite(PIO_IRQMASK, 32'h0);
        peek(PIO_EDGECAP);
        checkOutput("unmask_irq_a", {31'h0, irq_a}, 32'h0);
        checkOutput("unmask_irq_b", {31'h0, irq_b}, 32'h0);
        checkOutput("unmask_cap_a", rd_a, 32'h2);

        // Falling edge on bit2 captured by the falling-edge instance.
        @(posedge clk);
        #1;
        in_port = 4'b0001;
        repeat (12) @(posedge clk);
        peek(PIO_EDGECAP);
        checkOutput("fall2_cap_a", rd_a, 32'h6);
        checkOutput("fall2_cap_b", rd_b, 32'h6);
        peek(PIO_DATA);
        checkOutput("fall2_data_a", rd_a, 32'h1);
        checkOutput("fall2_data_b", rd_b, 32'h1);
        busWrite(PIO_EDGECAP, 32'hF);

        // W1C on the same edge as a new capture: the capture wins.
        in_port = 4'b0011;
        repeat (9) @(posedge clk);
        #1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = PIO_EDGECAP;
        writedata  = 32'h2;
        @(posedge clk);
        #1;
        write_n    = 1'b1;
        chipselect = 1'b0;
        peek(PIO_EDGECAP);
        checkOutput("setwins_cap_a", rd_a, 32'h2);
        checkOutput("setwins_cap_b", rd_b, 32'h0);

        // Reset in the middle of a debounce count.
        busWrite(PIO_EDGECAP, 32'hF);
        busWrite(PIO_IRQMASK, 32'hF);
        in_port = 4'b1011;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        in_port = 4'b0101;
        #1;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = PIO_DATA;
        #1;
        checkOutput("rst_data_a", rd_a, 32'h5);
        checkOutput("rst_data_b", rd_b, 32'h0);
        address = PIO_IRQMASK;
        #1;
        checkOutput("rst_mask_a", rd_a, 32'h0);
        checkOutput("rst_mask_b", rd_b, 32'h0);
        checkOutput("rst_irq_a", {31'h0, irq_a}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        peek(PIO_EDGECAP);
        checkOutput("postrst_cap_a", rd_a, 32'h0);
        checkOutput("postrst_cap_b", rd_b, 32'h0);
        peek(PIO_DATA);
        checkOutput("postrst_data_a", rd_a, 32'h5);
        checkOutput("postrst_data_b", rd_b, 32'h5);

        // Randomised traffic checked every cycle against the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset_n    = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            if (hold == 0) begin
                in_port = 4'($urandom);
                hold    = $urandom_range(1, 14);
            end
            hold--;
        end
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
